// File: rtl/vga_sink.sv
// vga_sink: VGA timing receiver and frame capture.
// Recovers line/frame position from hsync/vsync sampled on pix_en, locks to
// the frame timing, emits captured active-area pixels with coordinates, and
// counts malformed lines/frames.
// Optional feature: define VGA_SINK_CRC_EN to build the per-frame checksum;
// without it frame_crc_o is tied to zero.
module vga_sink #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525,
    parameter bit SYNC_LOW = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_en_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [11:0] rgb_i,
    output logic        locked_o,
    output logic        pix_valid_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic [11:0] pixel_o,
    output logic        frame_done_o,
    output logic [15:0] frame_crc_o,
    output logic [7:0]  line_err_o,
    output logic [7:0]  frame_err_o
);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    localparam logic [11:0] H_A0   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_A1   = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_A0   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_A1   = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    state_t      state_q;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        hs_prev_q, vs_prev_q;
    logic        vs_seen_q, vs_seen_d;
    logic        locked_q, pix_valid_q, frame_done_q;
    logic [11:0] x_q, y_q, pixel_q;
    logic [7:0]  line_err_q, frame_err_q;

    // Sync lines normalised to "asserted = 1"
    logic hs_act, vs_act, hs_edge, vs_edge, reload;
    logic lk, line_ev, frame_bad_ev, frame_ok_ev, active;

    assign hs_act  = SYNC_LOW ? ~hsync_i : hsync_i;
    assign vs_act  = SYNC_LOW ? ~vsync_i : vsync_i;
    assign hs_edge = pix_en_i & hs_act & ~hs_prev_q;
    assign vs_edge = pix_en_i & vs_act & ~vs_prev_q;
    // vcnt restarts on the first hsync edge at or after a vsync edge
    assign reload  = hs_edge & (vs_seen_q | vs_edge);

    // Timing checks only matter while locked; line check wins over frame check
    assign lk           = (state_q == LOCKED);
    assign line_ev      = lk & hs_edge & (hcnt_q != H_LAST);
    assign frame_bad_ev = lk & reload & ~line_ev & (vcnt_q != V_LAST);
    assign frame_ok_ev  = lk & reload & ~line_ev & (vcnt_q == V_LAST);

    // Next horizontal/vertical position for the current sample
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        vs_seen_d = vs_seen_q;
        if (pix_en_i) begin
            if (hs_edge)
                hcnt_d = '0;
            else if (hcnt_q != 12'hFFF)
                hcnt_d = hcnt_q + 12'd1;
        end
        if (hs_edge) begin
            vs_seen_d = 1'b0;
            if (reload)
                vcnt_d = '0;
            else if (vcnt_q != 12'hFFF)
                vcnt_d = vcnt_q + 12'd1;
        end else if (vs_edge) begin
            vs_seen_d = 1'b1;
        end
    end

    // The sample's coordinate is the updated counter value; the edge sample
    // itself sits at hcnt 0, which is never active, so state_q suffices here
    assign active = lk & pix_en_i &
                    (hcnt_d >= H_A0) & (hcnt_d < H_A1) &
                    (vcnt_d >= V_A0) & (vcnt_d < V_A1);

    // Alignment FSM, position counters, capture and error counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= SEARCH;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            vs_seen_q    <= 1'b0;
            locked_q     <= 1'b0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pixel_q      <= '0;
            line_err_q   <= '0;
            frame_err_q  <= '0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            vs_seen_q    <= vs_seen_d;
            if (pix_en_i) begin
                hs_prev_q <= hs_act;
                vs_prev_q <= vs_act;
            end
            pix_valid_q  <= active;
            frame_done_q <= 1'b0;
            if (active) begin
                x_q     <= hcnt_d - H_A0;
                y_q     <= vcnt_d - V_A0;
                pixel_q <= rgb_i;
            end
            case (state_q)
                SEARCH: begin
                    // vsync and hsync edges together already mark line 0
                    if (vs_edge) begin
                        state_q  <= reload ? LOCKED : ALIGN;
                        locked_q <= reload;
                    end
                end
                ALIGN: begin
                    if (reload) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (line_ev) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        if (line_err_q != 8'hFF) line_err_q <= line_err_q + 8'd1;
                    end else if (frame_bad_ev) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        if (frame_err_q != 8'hFF) frame_err_q <= frame_err_q + 8'd1;
                    end else if (frame_ok_ev) begin
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_SINK_CRC_EN
    logic [15:0] sum_q, crc_q;

    // Running rotate/XOR checksum; latched and restarted at each good frame end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            crc_q <= '0;
        end else if (line_ev | frame_bad_ev) begin
            sum_q <= '0;
        end else if (frame_ok_ev) begin
            crc_q <= sum_q;
            sum_q <= '0;
        end else if (active) begin
            sum_q <= {sum_q[14:0], sum_q[15]} ^ {4'b0, rgb_i};
        end
    end

    assign frame_crc_o = crc_q;
`else
    assign frame_crc_o = '0;
`endif

    assign locked_o     = locked_q;
    assign pix_valid_o  = pix_valid_q;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign pixel_o      = pixel_q;
    assign frame_done_o = frame_done_q;
    assign line_err_o   = line_err_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_vga_sink.sv
// tb_vga_sink: directed checks of vga_sink on a reduced 10x6 timing
// (4x3 active area) so whole frames fit in a short run.
module tb_vga_sink;
    localparam int HA = 4, HS = 2, HB = 2, HT = 10;
    localparam int VA = 3, VS = 1, VB = 1, VT = 6;
`ifdef VGA_SINK_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, pix_en = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1;
    logic [11:0] rgb = '0;
    logic        locked, pix_valid, frame_done;
    logic [11:0] x, y, pixel;
    logic [15:0] frame_crc;
    logic [7:0]  line_err, frame_err;

    int n_chk = 0, n_pass = 0, gap = 4, idle_hi = 0;

    vga_sink #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .SYNC_LOW(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en), .hsync_i(hsync),
        .vsync_i(vsync), .rgb_i(rgb), .locked_o(locked), .pix_valid_o(pix_valid),
        .x_o(x), .y_o(y), .pixel_o(pixel), .frame_done_o(frame_done),
        .frame_crc_o(frame_crc), .line_err_o(line_err), .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One pix_en sample preceded by gap-1 idle clocks; hs/vs given as asserted
    task automatic step(input logic hs, input logic vs, input logic [11:0] c);
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
            if (pix_valid || frame_done) idle_hi++;
        end
        hsync = ~hs; vsync = ~vs; rgb = c; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    // Send nl lines; line sl is slen pixels long. first/last colour the
    // first and last active pixel. Returns capture count, frame_done count,
    // wrong x/y/pixel count, and frame_crc seen with the last frame_done.
    task automatic frame(input int nl, input bit vs_on, input int sl, input int slen,
                         input logic [11:0] base, input logic [11:0] first,
                         input logic [11:0] last, output int nv, output int nd,
                         output int nbad, output logic [15:0] crc_d);
        nv = 0; nd = 0; nbad = 0; crc_d = '0;
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == sl) ? slen : HT;
            for (int p = 0; p < len; p++) begin
                logic [11:0] c;
                c = (l == VS + VB && p == HS + HB) ? first :
                    (l == VS + VB + VA - 1 && p == HS + HB + HA - 1) ? last : base;
                step(p < HS, vs_on && l < VS, c);
                if (frame_done) begin nd++; crc_d = frame_crc; end
                if (pix_valid) begin
                    nv++;
                    if (x !== 12'(p - HS - HB) || y !== 12'(l - VS - VB) || pixel !== c)
                        nbad++;
                end
            end
        end
    endtask

    initial begin
        int nv, nd, nb;
        logic [15:0] cr;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_locked", locked, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_line_err", line_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_crc", frame_crc, 0);

        // A: solid F00 with distinct corner pixels, locks on first sample
        frame(VT, 1, -1, 0, 12'hF00, 12'hABC, 12'h123, nv, nd, nb, cr);
        check("A_locked", locked, 1);
        check("A_nvalid", nv, VA * HA);
        check("A_xy_pixel", nb, 0);
        check("A_done", nd, 0);

        // B: zeros with 001 as last active pixel
        frame(VT, 1, -1, 0, 12'h000, 12'h000, 12'h001, nv, nd, nb, cr);
        check("B_done", nd, 1);
        check("B_nvalid", nv, VA * HA);
        check("B_xy_pixel", nb, 0);

        // C: all-zero frame; B's checksum is latched at its start
        frame(VT, 1, -1, 0, 12'h000, 12'h000, 12'h000, nv, nd, nb, cr);
        check("C_done", nd, 1);
        check("C_crc_of_B", cr, CRC_ON ? 32'h1 : 32'h0);

        // D: line 3 is 9 pixels -> line error, lock lost at line 4
        frame(VT, 1, 3, HT - 1, 12'h000, 12'h000, 12'h000, nv, nd, nb, cr);
        check("D_done", nd, 1);
        check("D_crc_of_C", cr, 0);
        check("D_line_err", line_err, 1);
        check("D_locked", locked, 0);
        check("D_nvalid", nv, 8);

        // E: relock; no frame_done for D
        frame(VT, 1, -1, 0, 12'h000, 12'h000, 12'h001, nv, nd, nb, cr);
        check("E_done", nd, 0);
        check("E_locked", locked, 1);
        check("E_nvalid", nv, VA * HA);

        // F: only 5 lines
        frame(VT - 1, 1, -1, 0, 12'h000, 12'h000, 12'h002, nv, nd, nb, cr);
        check("F_done", nd, 1);
        check("F_crc_of_E", cr, CRC_ON ? 32'h1 : 32'h0);
        check("F_nvalid", nv, VA * HA);

        // G: its start reveals F's short frame
        frame(VT, 1, -1, 0, 12'h000, 12'h000, 12'h000, nv, nd, nb, cr);
        check("G_done", nd, 0);
        check("G_frame_err", frame_err, 1);
        check("G_line_err", line_err, 1);
        check("G_locked", locked, 0);
        check("G_nvalid", nv, 0);
        check("G_crc_held", frame_crc, CRC_ON ? 32'h1 : 32'h0);

        // 300 lock / short-line cycles -> line_err saturates
        gap = 1;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 12'h0);
            step(1'b0, 1'b0, 12'h0);
            step(1'b1, 1'b0, 12'h0);
            step(1'b0, 1'b0, 12'h0);
        end
        check("SAT_line_err", line_err, 255);
        check("SAT_frame_err", frame_err, 1);
        check("SAT_locked", locked, 0);
        gap = 4;

        // Reset mid-frame, then no relock without a fresh vsync edge
        frame(3, 1, -1, 0, 12'h000, 12'h000, 12'h000, nv, nd, nb, cr);
        check("R_pre_locked", locked, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("R_locked", locked, 0);
        check("R_line_err", line_err, 0);
        check("R_frame_err", frame_err, 0);
        frame(VT, 0, -1, 0, 12'h000, 12'h000, 12'h000, nv, nd, nb, cr);
        check("R_novs_locked", locked, 0);
        check("R_novs_nvalid", nv, 0);
        frame(VT, 1, -1, 0, 12'h000, 12'h000, 12'h000, nv, nd, nb, cr);
        check("R_relock", locked, 1);
        check("R_relock_nvalid", nv, VA * HA);
        check("R_relock_frame_crc", frame_crc, 0);

        check("idle_strobes_low", idle_hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_sink.md
VGA_SINK -- requirements
Module: vga_sink

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter H_SYNC / H_BP / H_TOTAL, 96 / 48 / 800, hsync width, back porch and line period in pixels.
REQ-003 Parameter V_ACTIVE, 480, active lines per frame.
REQ-004 Parameter V_SYNC / V_BP / V_TOTAL, 2 / 33 / 525, vsync width, back porch and frame period in lines.
REQ-005 Parameter SYNC_LOW, 1, 1 = hsync/vsync asserted low.
REQ-006 clk  in  1  system clock (100 MHz).
REQ-007 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-008 pix_en  in  1  pixel strobe; all VGA inputs sampled only on clk edges with pix_en=1.
REQ-009 hsync, vsync  in  1 each  VGA sync lines under test.
REQ-010 rgb  in  12  {R,G,B} 4 bits each.
REQ-011 locked  out  1  receiver aligned to frame timing.
REQ-012 pix_valid  out  1  one-clk strobe, active-area pixel captured.
REQ-013 x, y  out  12 each  coordinates of captured pixel.
REQ-014 pixel  out  12  captured rgb.
REQ-015 frame_done  out  1  one-clk pulse at each correctly timed frame boundary.
REQ-016 frame_crc  out  16  checksum of last completed frame.
REQ-017 line_err, frame_err  out  8 each  saturating timing-error counts.

Function
REQ-018 Leading edge = sample asserted while previous pix_en sample deasserted; evaluated per pix_en sample only.
REQ-019 hcnt (12 bit) SHALL load 0 on hsync leading edge, else increment per pix_en sample, saturating at 4095.
REQ-020 vcnt (12 bit) SHALL increment on each hsync leading edge; load 0 instead if a vsync leading edge was seen since the previous hsync leading edge, including the same sample.
REQ-021 States SEARCH, ALIGN, LOCKED; SEARCH->ALIGN on vsync leading edge; ALIGN->LOCKED on next hsync leading edge (vcnt=0).
REQ-022 In LOCKED, hsync leading edge with previous hcnt != H_TOTAL-1 SHALL increment line_err and go SEARCH.
REQ-023 In LOCKED, vcnt reload with previous vcnt != V_TOTAL-1 SHALL increment frame_err, go SEARCH, suppress frame_done.
REQ-024 In LOCKED, vcnt reload with previous vcnt = V_TOTAL-1 SHALL pulse frame_done and latch frame_crc in the same clk.
REQ-025 Line-error check takes priority; if both fire on one sample only line_err increments.
REQ-026 Active pixel: LOCKED, hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-027 For an active pixel, pix_valid, x = hcnt-(H_SYNC+H_BP), y = vcnt-(V_SYNC+V_BP), pixel = rgb SHALL appear one clk after the sampling edge; pix_valid low otherwise.
REQ-028 locked = (state == LOCKED), registered.
REQ-029 Error counters SHALL saturate at 255 and clear only on rst.
REQ-030 Leaving LOCKED SHALL clear the running checksum; frame_crc holds its last value.

Reset
REQ-031 On rst: state SEARCH, hcnt/vcnt 0, previous-sync samples deasserted, all outputs 0.
REQ-032 rst mid-frame SHALL discard partial frame; relock requires a fresh vsync leading edge.

Configuration
REQ-033 Macro VGA_SINK_CRC_EN defined: running sum = rotate-left-1(sum) XOR {4'b0, pixel} per active pixel, cleared at each frame boundary after latching.
REQ-034 Macro undefined: no checksum logic; frame_crc constant 0; all other behaviour identical.

Verification
REQ-035 Nominal 640x480 stream, pix_en every 4th clk, solid rgb 12'hF00 -> locked after first vsync+hsync, 307200 pix_valid per frame, x 0..639, y 0..479, frame_done once per frame.
REQ-036 Pixel (0,0)=12'hABC, (639,479)=12'h123 -> captured with matching x/y and pixel one clk after sample.
REQ-037 One line of 799 pixels -> line_err=1, locked drops, no frame_done for that frame, relock on next vsync.
REQ-038 Frame of 524 lines -> frame_err=1, frame_done suppressed, frame_crc unchanged.
REQ-039 300 consecutive short lines with relock each frame -> line_err saturates at 255.
REQ-040 VGA_SINK_CRC_EN defined, all-zero frame -> frame_crc=16'h0000; single pixel 12'h001 as last active pixel -> frame_crc=16'h0001; macro undefined -> frame_crc=0 always.
